// File: rtl/cpu_pkg.sv
// Shared CPU types and widths for the writeback stage, the ID stage and the hazard unit.
// No logic and no latency; the enum encoding below is relied on by anything that decodes the WB state.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_LD = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback result select with priority link > load data > ALU result.
// Purely combinational, so it adds no latency and applies no backpressure.
module wb_mux #(
    parameter int DATA_W = 16
) (
    input  logic              i_link,
    input  logic              i_mem2reg,
    input  logic [DATA_W-1:0] i_pcPlus1,
    input  logic [DATA_W-1:0] i_memRdData,
    input  logic [DATA_W-1:0] i_aluRes,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_aluRes;
        if (i_link) begin
            o_data = i_pcPlus1;
        end else if (i_mem2reg) begin
            o_data = i_memRdData;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register and RF write port: 1-cycle latency from accept to o_wrEn/o_wrReg/o_wrData.
// Stalls upstream combinationally on a pending load and from halt capture until reset.
module wb_stage #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_wrReg,
    input  logic              i_wrRegEn,
    input  logic              i_mem2reg,
    input  logic              i_link,
    input  logic              i_memRd,
    input  logic              i_memRdy,
    input  logic [DATA_W-1:0] i_aluRes,
    input  logic [DATA_W-1:0] i_memRdData,
    input  logic [DATA_W-1:0] i_pcPlus1,
    input  logic              i_hlt,
    output logic [REG_AW-1:0] o_wrReg,
    output logic [DATA_W-1:0] o_wrData,
    output logic              o_wrEn,
    output logic              o_stall,
    output logic              o_hlt,
    output logic              o_hltDone
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    wb_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [REG_AW-1:0]  r_wrReg;
    logic [DATA_W-1:0]  r_wrData;
    logic               r_wrEn;
    logic               r_hltDone;

    logic               w_ldMiss;
    logic               w_capture;
    logic               w_stall;
    logic [DATA_W-1:0]  w_selData;

    wb_mux #(
        .DATA_W(DATA_W)
    ) u_wb_mux (
        .i_link     (i_link),
        .i_mem2reg  (i_mem2reg),
        .i_pcPlus1  (i_pcPlus1),
        .i_memRdData(i_memRdData),
        .i_aluRes   (i_aluRes),
        .o_data     (w_selData)
    );

    // HLT outranks a load, so a halting instruction never waits on memory.
    assign w_ldMiss = i_valid & i_memRd & ~i_memRdy & ~i_hlt;

    always_comb begin
        w_stall   = 1'b1;
        w_capture = 1'b0;
        case (r_state)
            RUN: begin
                w_stall   = w_ldMiss;
                w_capture = i_valid & ~w_ldMiss;
            end
            WAIT_LD: begin
                w_stall   = ~i_memRdy;
                w_capture = i_memRdy;
            end
            default: begin
                w_stall   = 1'b1;
                w_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_wrReg   <= '0;
            r_wrData  <= '0;
            r_wrEn    <= 1'b0;
            r_hltDone <= 1'b0;
        end else begin
            r_wrEn <= 1'b0;
            // R0 writes still move the address/data registers; only the strobe is suppressed.
            if (w_capture) begin
                r_wrReg  <= i_wrReg;
                r_wrData <= w_selData;
                r_wrEn   <= i_wrRegEn & (|i_wrReg) & ~i_hlt;
            end
            case (r_state)
                RUN: begin
                    if (i_valid & i_hlt) begin
                        r_state <= DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                    end else if (w_ldMiss) begin
                        r_state <= WAIT_LD;
                    end
                end
                WAIT_LD: begin
                    if (i_memRdy) begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state   <= HALTED;
                        r_hltDone <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                HALTED: begin
                    r_hltDone <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign o_wrReg   = r_wrReg;
    assign o_wrData  = r_wrData;
    assign o_wrEn    = r_wrEn;
    assign o_stall   = w_stall;
    assign o_hlt     = (r_state == HALTED);
    assign o_hltDone = r_hltDone;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scenarios then randomized traffic for wb_stage, checked cycle by cycle against a reference model.
module tb_wb_stage;

    localparam int DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic [3:0]  wrReg;
    logic        wrRegEn;
    logic        mem2reg;
    logic        link;
    logic        memRd;
    logic        memRdy;
    logic [15:0] alu;
    logic [15:0] md;
    logic [15:0] pc;
    logic        hlt;

    logic [3:0]  o_wrReg;
    logic [15:0] o_wrData;
    logic        o_wrEn;
    logic        o_stall;
    logic        o_hlt;
    logic        o_hltDone;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: abstract pipeline situation plus the expected RF write port.
    bit          m_wait;
    bit          m_drain;
    bit          m_halt;
    int          m_left;
    bit          e_en;
    logic [3:0]  e_reg;
    logic [15:0] e_data;
    logic        s_stall;

    always #5 clk = ~clk;

    wb_stage #(
        .DATA_W      (16),
        .REG_AW      (4),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (v),
        .i_wrReg    (wrReg),
        .i_wrRegEn  (wrRegEn),
        .i_mem2reg  (mem2reg),
        .i_link     (link),
        .i_memRd    (memRd),
        .i_memRdy   (memRdy),
        .i_aluRes   (alu),
        .i_memRdData(md),
        .i_pcPlus1  (pc),
        .i_hlt      (hlt),
        .o_wrReg    (o_wrReg),
        .o_wrData   (o_wrData),
        .o_wrEn     (o_wrEn),
        .o_stall    (o_stall),
        .o_hlt      (o_hlt),
        .o_hltDone  (o_hltDone)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b0; v = 1'b0; wrReg = 4'd0; wrRegEn = 1'b0; mem2reg = 1'b0;
        link = 1'b0; memRd = 1'b0; memRdy = 1'b0; alu = 16'd0; md = 16'd0;
        pc = 16'd0; hlt = 1'b0;
    endtask

    // One clock: check the combinational stall, advance the model, check the registered outputs.
    task automatic tick();
        bit exp_stall;
        bit take;
        @(negedge clk);
        if (m_halt || m_drain)
            exp_stall = 1'b1;
        else if (m_wait)
            exp_stall = !memRdy;
        else
            exp_stall = v && memRd && !memRdy && !hlt;
        s_stall = o_stall;
        if (!rst) chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});

        if (rst) begin
            m_wait = 0; m_drain = 0; m_halt = 0; m_left = 0;
            e_en = 0; e_reg = 4'd0; e_data = 16'd0;
        end else begin
            e_en = 0;
            if (m_drain) begin
                m_left--;
                if (m_left == 0) begin
                    m_drain = 0;
                    m_halt  = 1;
                end
            end else if (!m_halt) begin
                take = m_wait ? memRdy : (v && !exp_stall);
                if (take) begin
                    e_reg  = wrReg;
                    e_data = link ? pc : (mem2reg ? md : alu);
                    e_en   = wrRegEn && (wrReg != 4'd0) && !hlt;
                    if (hlt) begin
                        m_drain = 1;
                        m_left  = DRAIN;
                    end
                    m_wait = 0;
                end else if (exp_stall) begin
                    m_wait = 1;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("wrEn",    {31'd0, o_wrEn},    {31'd0, e_en});
        chk("wrReg",   {28'd0, o_wrReg},   {28'd0, e_reg});
        chk("wrData",  {16'd0, o_wrData},  {16'd0, e_data});
        chk("hlt",     {31'd0, o_hlt},     {31'd0, m_halt});
        chk("hltDone", {31'd0, o_hltDone}, {31'd0, m_halt});
    endtask

    initial begin
        m_wait = 0; m_drain = 0; m_halt = 0; m_left = 0;
        e_en = 0; e_reg = 4'd0; e_data = 16'd0; s_stall = 1'b0;
        clr();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wrEn", {31'd0, o_wrEn}, 32'd0);
        chk("rst_data", {16'd0, o_wrData}, 32'd0);
        rst = 1'b0;

        // ALU write
        v = 1'b1; wrReg = 4'd3; wrRegEn = 1'b1; alu = 16'h1234;
        tick();
        chk("t1_en", {31'd0, o_wrEn}, 32'd1);
        chk("t1_reg", {28'd0, o_wrReg}, 32'd3);
        chk("t1_data", {16'd0, o_wrData}, 32'h1234);

        // R0 suppressed, data still updates
        wrReg = 4'd0; alu = 16'hFFFF;
        tick();
        chk("t2_en", {31'd0, o_wrEn}, 32'd0);
        chk("t2_data", {16'd0, o_wrData}, 32'hFFFF);

        // Slow load: two stalled cycles, then data
        clr();
        v = 1'b1; memRd = 1'b1; mem2reg = 1'b1; wrRegEn = 1'b1; wrReg = 4'd5; alu = 16'h7777;
        tick();
        chk("t3_stall0", {31'd0, s_stall}, 32'd1);
        tick();
        chk("t3_stall1", {31'd0, s_stall}, 32'd1);
        memRdy = 1'b1; md = 16'hBEEF;
        tick();
        chk("t3_stall2", {31'd0, s_stall}, 32'd0);
        chk("t3_en", {31'd0, o_wrEn}, 32'd1);
        chk("t3_reg", {28'd0, o_wrReg}, 32'd5);
        chk("t3_data", {16'd0, o_wrData}, 32'hBEEF);

        // Link beats load data
        clr();
        v = 1'b1; link = 1'b1; mem2reg = 1'b1; pc = 16'h0042; md = 16'h9999;
        wrReg = 4'd15; wrRegEn = 1'b1;
        tick();
        chk("t6_data", {16'd0, o_wrData}, 32'h0042);
        chk("t6_en", {31'd0, o_wrEn}, 32'd1);

        // Reset in the middle of a load wait
        clr();
        v = 1'b1; memRd = 1'b1; mem2reg = 1'b1; wrRegEn = 1'b1; wrReg = 4'd7;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_en", {31'd0, o_wrEn}, 32'd0);
        chk("t5_reg", {28'd0, o_wrReg}, 32'd0);
        chk("t5_data", {16'd0, o_wrData}, 32'd0);
        clr();
        v = 1'b1; wrReg = 4'd9; wrRegEn = 1'b1; alu = 16'hA5A5;
        tick();
        chk("t5_stall", {31'd0, s_stall}, 32'd0);
        chk("t5_after", {16'd0, o_wrData}, 32'hA5A5);
        chk("t5_after_en", {31'd0, o_wrEn}, 32'd1);

        // Halt drain with younger ALU ops behind it
        clr();
        v = 1'b1; hlt = 1'b1; wrRegEn = 1'b1; wrReg = 4'd2;
        tick();
        hlt = 1'b0;
        chk("t4_en_h", {31'd0, o_wrEn}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            alu = 16'(i + 16'h100);
            tick();
            chk("t4_en", {31'd0, o_wrEn}, 32'd0);
            chk("t4_hlt", {31'd0, o_hlt}, (i >= 2) ? 32'd1 : 32'd0);
            chk("t4_done", {31'd0, o_hltDone}, (i >= 2) ? 32'd1 : 32'd0);
        end

        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Random traffic; inputs are held while a load waits, only memRdy/data change
        for (int n = 0; n < 3000; n++) begin
            rst    = (m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0));
            memRdy = $urandom_range(0, 1);
            md     = 16'($urandom);
            if (!m_wait) begin
                v       = ($urandom_range(0, 3) != 0);
                wrReg   = 4'($urandom);
                wrRegEn = $urandom_range(0, 1);
                mem2reg = $urandom_range(0, 1);
                link    = ($urandom_range(0, 4) == 0);
                memRd   = ($urandom_range(0, 2) == 0);
                alu     = 16'($urandom);
                pc      = 16'($urandom);
                hlt     = ($urandom_range(0, 59) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
